// File: rtl/snax_hwpe_periph_regfile_if.sv
// rtl/snax_hwpe_periph_regfile_if.sv - 32-bit HWPE peripheral control interface
interface hwpe_ctrl_intf_periph #(
    parameter int unsigned ID_WIDTH = 5
) ();
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic                r_valid;
    logic [31:0]         r_data;
    logic [ID_WIDTH-1:0] r_id;

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_valid, r_data, r_id
    );

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_valid, r_data, r_id
    );
endinterface

// File: rtl/snax_hwpe_periph_regfile.sv
// rtl/snax_hwpe_periph_regfile.sv - HWPE peripheral register file with trigger, status and config words
module snax_hwpe_periph_regfile #(
    parameter int unsigned NumCfg  = 6,
    parameter int unsigned IdWidth = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    hwpe_ctrl_intf_periph.slave    periph,
    output logic [NumCfg*32-1:0]   cfg_o,
    output logic                   start_o,
    output logic                   busy_o,
    input  logic                   done_i
);
    localparam int unsigned NumWords = 2 + NumCfg;

    logic [29:0]        idx;
    logic               is_trig;
    logic               is_stat;
    logic               in_range;
    logic               is_cfg;
    logic               accept;
    logic               rd_acc;
    logic               wr_acc;
    logic               trig_go;
    logic               err_set;
    logic               err_clr;
    logic               cfg_wr;
    logic [31:0]        cfg_rd;
    logic [31:0]        rd_word;
    logic [31:0]        status;

    logic [31:0]        cfg_q [NumCfg];
    logic               r_valid_q;
    logic [31:0]        r_data_q;
    logic [IdWidth-1:0] r_id_q;
    logic               start_q;
    logic               busy_q;
    logic               err_q;
    logic [15:0]        jobcnt_q;

    logic               unused;
    assign unused = ^periph.add[1:0];

    assign idx      = periph.add[31:2];
    assign is_trig  = (idx == 30'd0);
    assign is_stat  = (idx == 30'd1);
    assign in_range = (idx < 30'(NumWords));
    assign is_cfg   = in_range & ~is_trig & ~is_stat;

    // Holding off grant while a response is out keeps a held req from being taken twice.
    assign periph.gnt = periph.req & ~r_valid_q;
    assign accept     = periph.req & periph.gnt;
    assign rd_acc     = accept & periph.wen;
    assign wr_acc     = accept & ~periph.wen;

    assign trig_go = wr_acc & is_trig & (|periph.be) & ~busy_q;
    assign cfg_wr  = wr_acc & is_cfg & ~busy_q;
    assign err_set = (wr_acc & (~in_range | is_stat | ((is_trig | is_cfg) & busy_q)))
                   | (done_i & ~busy_q);
    assign err_clr = rd_acc & is_stat;

    assign status = {jobcnt_q, 14'b0, err_q, busy_q};

    always_comb begin
        cfg_rd = '0;
        for (int k = 0; k < int'(NumCfg); k++) begin
            if (idx == 30'(k + 2)) begin
                cfg_rd = cfg_q[k];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (is_stat) begin
            rd_word = status;
        end else if (is_cfg) begin
            rd_word = cfg_rd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_id_q    <= '0;
        end else begin
            r_valid_q <= rd_acc;
            if (rd_acc) begin
                r_data_q <= rd_word;
                r_id_q   <= periph.id;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(NumCfg); k++) begin
                cfg_q[k] <= '0;
            end
        end else if (cfg_wr) begin
            for (int k = 0; k < int'(NumCfg); k++) begin
                if (idx == 30'(k + 2)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (periph.be[b]) begin
                            cfg_q[k][8*b +: 8] <= periph.data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // A trigger needs idle and a done needs busy, so the two never collide on busy_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            jobcnt_q <= '0;
        end else begin
            start_q <= trig_go;
            busy_q  <= busy_q ? ~done_i : trig_go;
            err_q   <= err_set | (err_q & ~err_clr);
            if (busy_q && done_i) begin
                jobcnt_q <= jobcnt_q + 16'd1;
            end
        end
    end

    for (genvar k = 0; k < int'(NumCfg); k++) begin : g_cfg_out
        assign cfg_o[32*k +: 32] = cfg_q[k];
    end

    assign periph.r_valid = r_valid_q;
    assign periph.r_data  = r_data_q;
    assign periph.r_id    = r_id_q;
    assign start_o        = start_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
// tb/tb_snax_hwpe_periph_regfile.sv - directed and randomized bench for snax_hwpe_periph_regfile
module tb_snax_hwpe_periph_regfile;
    localparam int NumCfg = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hwpe_ctrl_intf_periph #(.ID_WIDTH(5)) periph ();
    logic [NumCfg*32-1:0] cfg_o;
    logic                 start_o;
    logic                 busy_o;
    logic                 done_i;

    snax_hwpe_periph_regfile #(.NumCfg(NumCfg), .IdWidth(5)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .periph (periph),
        .cfg_o  (cfg_o),
        .start_o(start_o),
        .busy_o (busy_o),
        .done_i (done_i)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_cfg [NumCfg];
    logic        m_busy;
    logic        m_err;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] addr);
        int unsigned w;
        w = addr >> 2;
        if (w == 1) return {m_cnt, 14'b0, m_err, m_busy};
        if (w >= 2 && w < 2 + NumCfg) return m_cfg[w-2];
        return 32'h0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NumCfg; k++) m_cfg[k] = '0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic idle();
        periph.req  = 1'b0;
        periph.wen  = 1'b1;
        periph.add  = '0;
        periph.be   = '0;
        periph.data = '0;
        periph.id   = '0;
    endtask

    task automatic chk_cfg(input string tag);
        for (int k = 0; k < NumCfg; k++) chk(tag, cfg_o[32*k +: 32], m_cfg[k]);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                      input logic with_done);
        int unsigned w;
        logic        was_busy;
        logic        exp_start;
        w = addr >> 2;
        periph.req = 1'b1; periph.wen = 1'b0; periph.add = addr;
        periph.data = data; periph.be = be; done_i = with_done;
        @(negedge clk);
        chk("wr_gnt", periph.gnt, 1);
        was_busy  = m_busy;
        exp_start = 1'b0;
        if (w == 0) begin
            if (was_busy) m_err = 1'b1;
            else if (be != 4'h0) begin exp_start = 1'b1; m_busy = 1'b1; end
        end else if (w >= 2 && w < 2 + NumCfg) begin
            if (was_busy) m_err = 1'b1;
            else for (int b = 0; b < 4; b++) if (be[b]) m_cfg[w-2][8*b +: 8] = data[8*b +: 8];
        end else begin
            m_err = 1'b1;
        end
        if (with_done) begin
            if (was_busy) begin m_busy = 1'b0; m_cnt = m_cnt + 16'd1; end
            else m_err = 1'b1;
        end
        @(posedge clk); #1;
        idle(); done_i = 1'b0;
        chk("wr_start", start_o, exp_start);
        chk("wr_busy", busy_o, m_busy);
        chk("wr_rvalid", periph.r_valid, 0);
        chk_cfg("wr_cfg");
        @(posedge clk); #1;
        chk("start_drop", start_o, 0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [4:0] id);
        logic [31:0] exp;
        exp = m_word(addr);
        periph.req = 1'b1; periph.wen = 1'b1; periph.add = addr; periph.id = id;
        periph.be = 4'($urandom); periph.data = $urandom;
        @(negedge clk);
        chk("rd_gnt", periph.gnt, 1);
        @(posedge clk); #1;
        if ((addr >> 2) == 1) m_err = 1'b0;
        idle();
        @(negedge clk);
        chk("rd_rvalid", periph.r_valid, 1);
        chk("rd_rid", periph.r_id, id);
        chk("rd_rdata", periph.r_data, exp);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_rvalid_drop", periph.r_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic done_pulse();
        done_i = 1'b1;
        if (m_busy) begin m_busy = 1'b0; m_cnt = m_cnt + 16'd1; end
        else m_err = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        chk("done_busy", busy_o, m_busy);
    endtask

    initial begin
        logic [31:0] a;
        idle();
        done_i = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", periph.gnt, 0);
        chk("rst_rvalid", periph.r_valid, 0);
        chk("rst_rdata", periph.r_data, 0);
        chk("rst_rid", periph.r_id, 0);
        chk("rst_start", start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk_cfg("rst_cfg");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        rd(32'h4, 5'd3);
        chk("status_reset", m_word(32'h4), 32'h0);
        wr(32'h8, 32'hA5A5_1234, 4'b0011, 1'b0);
        chk("cfg0_lane", cfg_o[31:0], 32'h0000_1234);
        rd(32'h8, 5'd9);

        wr(32'h0, 32'h0, 4'hF, 1'b0);
        wr(32'hC, 32'hDEAD_BEEF, 4'hF, 1'b0);
        chk("cfg1_locked", cfg_o[63:32], 32'h0);
        chk("status_busy_err", m_word(32'h4), 32'h0000_0003);
        rd(32'h4, 5'd1);
        chk("status_cleared", m_word(32'h4), 32'h0000_0001);
        rd(32'h4, 5'd2);
        done_pulse();
        rd(32'h4, 5'd4);

        // held read request: one accept, grant withdrawn while the response is out
        periph.req = 1'b1; periph.wen = 1'b1; periph.add = 32'h8; periph.id = 5'd7;
        @(negedge clk);
        chk("hold_gnt0", periph.gnt, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_gnt1", periph.gnt, 0);
        chk("hold_rvalid1", periph.r_valid, 1);
        chk("hold_rdata", periph.r_data, m_cfg[0]);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("hold_rvalid2", periph.r_valid, 0);
        @(posedge clk); #1;

        rd(32'h40, 5'd5);
        chk("oor_err_clear", {31'b0, m_err}, 0);
        wr(32'h40, 32'h1, 4'hF, 1'b0);
        rd(32'h4, 5'd6);

        // trigger and done landing on the same edge
        wr(32'h0, 32'h0, 4'hF, 1'b0);
        wr(32'h0, 32'h0, 4'hF, 1'b1);
        rd(32'h4, 5'd8);
        done_pulse();
        rd(32'h4, 5'd10);

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0, 1: wr({$urandom_range(2, 2 + NumCfg - 1), 2'($urandom)}, $urandom, 4'($urandom), 1'b0);
                2: begin
                    a = {$urandom_range(0, 17), 2'($urandom)};
                    rd(a, 5'($urandom));
                end
                3: wr({30'd0, 2'($urandom)}, $urandom, 4'($urandom), 1'($urandom));
                4: done_pulse();
                default: wr({$urandom_range(2 + NumCfg, 40), 2'b00}, $urandom, 4'($urandom), 1'b0);
            endcase
        end
        rd(32'h4, 5'd11);

        if (m_busy) done_pulse();
        for (int j = 0; j < 300; j++) begin
            periph.req = 1'b1; periph.wen = 1'b0; periph.add = 32'h0; periph.be = 4'hF;
            @(posedge clk); #1;
            idle(); done_i = 1'b1;
            @(posedge clk); #1;
            done_i = 1'b0;
            m_cnt = m_cnt + 16'd1;
        end
        chk("jobs_busy", busy_o, 0);
        rd(32'h4, 5'd12);

        // reset with a job in flight and a read response pending
        wr(32'h0, 32'h0, 4'hF, 1'b0);
        periph.req = 1'b1; periph.wen = 1'b1; periph.add = 32'h8; periph.id = 5'd13;
        @(posedge clk); #1;
        idle();
        chk("pre_rst_rvalid", periph.r_valid, 1);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("mid_rst_rvalid", periph.r_valid, 0);
        chk("mid_rst_rid", periph.r_id, 0);
        chk("mid_rst_rdata", periph.r_data, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk_cfg("mid_rst_cfg");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        rd(32'h4, 5'd14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
